// File: rtl/shift_register_sipo_if.sv
// Serial-in / parallel-out bus bundle: serial bit, shift enable, parallel word and word strobe.
// The master is the serial source; the slave is the shift register.
interface shift_register_sipo_if #(
    parameter int WIDTH = 4
);
    logic             Serial_IN;
    logic             Load;
    logic [WIDTH-1:0] OUT;
    logic             Word_Valid;

    modport master (
        output Serial_IN,
        output Load,
        input  OUT,
        input  Word_Valid
    );

    modport slave (
        input  Serial_IN,
        input  Load,
        output OUT,
        output Word_Valid
    );
endinterface

// File: rtl/shift_register_sipo.sv
// Serial-in, parallel-out shift register that deserializes a 1-bit stream into WIDTH-bit words
// and strobes Word_Valid for one cycle after every WIDTH accepted shifts.
module shift_register_sipo #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    shift_register_sipo_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_cnt;
    logic             r_word_valid;

    logic [WIDTH-1:0] w_shifted;
    logic             w_last;

    // Shift direction is fixed at elaboration; only one path exists in hardware.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_out[WIDTH-2:0], bus.Serial_IN};
        end else begin : g_lsb_first
            assign w_shifted = {bus.Serial_IN, r_out[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (r_cnt == LAST_BIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out        <= '0;
            r_cnt        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (bus.Load) begin
                r_out <= w_shifted;
                if (w_last) begin
                    r_cnt        <= '0;
                    r_word_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.OUT        = r_out;
    assign bus.Word_Valid = r_word_valid;
endmodule

// File: tb/tb_shift_register_sipo.sv
// Directed bench for shift_register_sipo: an MSB-first and an LSB-first instance at WIDTH=4,
// each step checked against hand-computed OUT and Word_Valid values.
module tb_shift_register_sipo;
    logic CLK;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_fail   = 0;

    shift_register_sipo_if #(.WIDTH(4)) if_a ();
    shift_register_sipo_if #(.WIDTH(4)) if_b ();

    shift_register_sipo #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .CLK (CLK),
        .RST (rst_a),
        .bus (if_a.slave)
    );

    shift_register_sipo #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .CLK (CLK),
        .RST (rst_b),
        .bus (if_b.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus to the MSB-first instance, then check after the edge.
    task automatic step_a(input string tag, input logic rst, input logic ld, input logic sin,
                          input logic [3:0] exp_out, input logic exp_wv);
        rst_a         = rst;
        if_a.Load     = ld;
        if_a.Serial_IN = sin;
        @(posedge CLK);
        #1;
        check({tag, " OUT"}, 64'(if_a.OUT), 64'(exp_out));
        check({tag, " WV"}, 64'(if_a.Word_Valid), 64'(exp_wv));
    endtask

    task automatic step_b(input string tag, input logic rst, input logic ld, input logic sin,
                          input logic [3:0] exp_out, input logic exp_wv);
        rst_b          = rst;
        if_b.Load      = ld;
        if_b.Serial_IN = sin;
        @(posedge CLK);
        #1;
        check({tag, " OUT"}, 64'(if_b.OUT), 64'(exp_out));
        check({tag, " WV"}, 64'(if_b.Word_Valid), 64'(exp_wv));
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.Load = 1'b1;
        if_a.Serial_IN = 1'b1;
        if_b.Load = 1'b1;
        if_b.Serial_IN = 1'b1;
        #1;

        // Reset with Load=1: reset wins, nothing shifts in.
        step_a("rst0", 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
        step_a("rst1", 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);

        // First word 1,0,1,1.
        step_a("w1b0", 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
        step_a("w1b1", 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0);
        step_a("w1b2", 1'b0, 1'b1, 1'b1, 4'b0101, 1'b0);
        step_a("w1b3", 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1);

        // Second word back-to-back 0,0,1,1.
        step_a("w2b0", 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0);
        step_a("w2b1", 1'b0, 1'b1, 1'b0, 4'b1100, 1'b0);
        step_a("w2b2", 1'b0, 1'b1, 1'b1, 4'b1001, 1'b0);
        step_a("w2b3", 1'b0, 1'b1, 1'b1, 4'b0011, 1'b1);

        // Hold with Serial_IN toggling.
        step_a("hold0", 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0);
        step_a("hold1", 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0);
        step_a("hold2", 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0);

        // Load gap mid-word keeps count progress.
        step_a("gap0", 1'b0, 1'b1, 1'b1, 4'b0111, 1'b0);
        step_a("gap1", 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
        step_a("gap2", 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
        step_a("gap3", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
        step_a("gap4", 1'b0, 1'b1, 1'b0, 4'b1110, 1'b0);
        step_a("gap5", 1'b0, 1'b1, 1'b1, 4'b1101, 1'b1);

        // Reset after two shifts discards the partial word.
        step_a("mr0", 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0);
        step_a("mr1", 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0);
        step_a("mr2", 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
        step_a("mr3", 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
        step_a("mr4", 1'b0, 1'b1, 1'b1, 4'b0011, 1'b0);
        step_a("mr5", 1'b0, 1'b1, 1'b1, 4'b0111, 1'b0);
        step_a("mr6", 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
        step_a("mr7", 1'b0, 1'b1, 1'b0, 4'b1110, 1'b0);
        if_a.Load = 1'b0;

        // LSB-first instance: shift 1,0,0,0 from reset.
        step_b("lrst", 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
        step_b("lb0", 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0);
        step_b("lb1", 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0);
        step_b("lb2", 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0);
        step_b("lb3", 1'b0, 1'b1, 1'b0, 4'b0001, 1'b1);
        step_b("lb4", 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
